// File: rtl/router_out_arb_if.sv
// Bus bundle for router_out_arb: input-FIFO read side plus the forwarded-word output side.
// out_valid/out_ready: a word transfers on a rising edge where both are high; once raised, out_valid,
// out_data and out_src hold steady until that transfer, and out_ready while out_valid is low is ignored.
interface router_out_arb_if #(
  parameter int DATA_W    = 32,
  parameter int NUM_PORTS = 8
);
  logic [NUM_PORTS-1:0]        fifo_empty;
  logic [NUM_PORTS*DATA_W-1:0] fifo_data;
  logic [NUM_PORTS-1:0]        fifo_rd;
  logic [DATA_W-1:0]           out_data;
  logic [2:0]                  out_src;
  logic                        out_valid;
  logic                        out_ready;
  logic                        busy;

  modport master (
    input  fifo_empty, fifo_data, out_ready,
    output fifo_rd, out_data, out_src, out_valid, busy
  );

  modport slave (
    output fifo_empty, fifo_data, out_ready,
    input  fifo_rd, out_data, out_src, out_valid, busy
  );
endinterface

// File: rtl/router_out_arb.sv
// Round-robin output arbiter: picks one non-empty input FIFO, reads one word and forwards it downstream.
// Optional macro ROUTER_ARB_DROP_ZERO_EN discards words captured as all-zero instead of forwarding them.
module router_out_arb #(
  parameter int DATA_W     = 32,
  parameter int NUM_PORTS  = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic              clock,
  input  logic              reset,
  router_out_arb_if.master  bus,
  output logic [1:0]        dbg_state
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [NUM_PORTS-1:0] rd_q, rd_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic [2:0]           src_q, src_d;
  logic                 valid_q, valid_d;

  logic                 hi_found, lo_found, arb_found;
  logic [IDX_W-1:0]     hi_pick, lo_pick, arb_pick;
  logic [DATA_W-1:0]    slice;
  logic [IDX_W-1:0]     grant_inc;
  logic                 drop_word;

  // Ports at or above rr_ptr win over ports below it, which gives the wrap-around search.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_pick  = '0;
    lo_pick  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!bus.fifo_empty[i]) begin
        if (IDX_W'(i) >= rr_ptr_q) begin
          if (!hi_found) begin
            hi_found = 1'b1;
            hi_pick  = IDX_W'(i);
          end
        end else if (!lo_found) begin
          lo_found = 1'b1;
          lo_pick  = IDX_W'(i);
        end
      end
    end
    arb_found = hi_found || lo_found;
    arb_pick  = hi_found ? hi_pick : lo_pick;
  end

  always_comb begin
    slice = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_q == IDX_W'(i)) slice = bus.fifo_data[i*DATA_W +: DATA_W];
    end
  end

  assign grant_inc = (grant_q == IDX_W'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;

`ifdef ROUTER_ARB_DROP_ZERO_EN
  assign drop_word = (slice == '0);
`else
  assign drop_word = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    rd_d     = '0;
    data_d   = data_q;
    src_d    = src_q;
    valid_d  = valid_q;
    unique case (state_q)
      IDLE: begin
        if (arb_found) begin
          grant_d = arb_pick;
          state_d = ISSUE;
          // fifo_rd is registered, so the pulse is loaded here and shows during ISSUE.
          for (int i = 0; i < NUM_PORTS; i++) rd_d[i] = (arb_pick == IDX_W'(i));
        end
      end
      ISSUE: begin
        cnt_d   = 4'(RD_LATENCY);
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          cnt_d = '0;
          if (drop_word) begin
            rr_ptr_d = grant_inc;
            state_d  = IDLE;
          end else begin
            data_d  = slice;
            src_d   = 3'(grant_q);
            valid_d = 1'b1;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (valid_q && bus.out_ready) begin
          valid_d  = 1'b0;
          rr_ptr_d = grant_inc;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      rd_q     <= '0;
      data_q   <= '0;
      src_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      rd_q     <= rd_d;
      data_q   <= data_d;
      src_q    <= src_d;
      valid_q  <= valid_d;
    end
  end

  assign bus.fifo_rd   = rd_q;
  assign bus.out_data  = data_q;
  assign bus.out_src   = src_q;
  assign bus.out_valid = valid_q;
  assign bus.busy      = (state_q != IDLE);
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_router_out_arb.sv
// Bench for router_out_arb: modelled input FIFOs with one-cycle read latency, directed scenarios
// and a randomized run scored against a round-robin reference model.
module tb_router_out_arb;
  localparam int DW = 32;
  localparam int NP = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] dbg_state;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;

  router_out_arb_if #(.DATA_W(DW), .NUM_PORTS(NP)) bus ();

  router_out_arb #(.DATA_W(DW), .NUM_PORTS(NP), .RD_LATENCY(1)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // FIFO contents live here; head/tail per port, empty flag derived from them.
  logic [DW-1:0] fmem [NP][64];
  int            head [NP];
  int            tail [NP];
  logic [NP-1:0] rd_prev;

  logic [2:0]    got_src  [64];
  logic [DW-1:0] got_data [64];
  int            got_cyc  [64];
  int            got_n;

  logic [DW+2:0] exp_q [$];

  task automatic refresh_empty();
    for (int i = 0; i < NP; i++) bus.fifo_empty[i] = (head[i] == tail[i]);
  endtask

  task automatic clear_fifos();
    for (int i = 0; i < NP; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    refresh_empty();
  endtask

  task automatic push(input int p, input logic [DW-1:0] d);
    fmem[p][tail[p]] = d;
    tail[p] = tail[p] + 1;
    refresh_empty();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.out_ready = 1'b0;
    clear_fifos();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(posedge clock);
      #1;
      if (bus.out_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic collect(input int n, input int budget);
    got_n = 0;
    for (int c = 0; c < budget && got_n < n; c++) begin
      @(posedge clock);
      #1;
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        got_src[got_n]  = bus.out_src;
        got_data[got_n] = bus.out_data;
        got_cyc[got_n]  = cyc;
        got_n = got_n + 1;
      end
    end
  endtask

  // FIFO read model: a pulse seen in one cycle presents the head word from the next cycle on.
  initial begin
    rd_prev = '0;
    forever begin
      @(posedge clock);
      #1;
      for (int i = 0; i < NP; i++) begin
        if (rd_prev[i] && head[i] != tail[i]) begin
          bus.fifo_data[i*DW +: DW] = fmem[i][head[i]];
          head[i] = head[i] + 1;
        end
      end
      refresh_empty();
      rd_prev = bus.fifo_rd;
      checks++;
      if ($countones(bus.fifo_rd) > 1 || (bus.fifo_rd !== '0 && bus.busy !== 1'b1)) begin
        errors++;
        $display("FAIL rd_onehot: fifo_rd=%h busy=%b, required at most one bit and only while busy",
                 bus.fifo_rd, bus.busy);
      end
      for (int i = 0; i < NP; i++) begin
        if (bus.fifo_rd[i] === 1'b1 && head[i] == tail[i]) begin
          errors++;
          $display("FAIL rd_empty: fifo_rd[%0d]=1 on empty FIFO, required 0", i);
        end
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    bus.out_ready = 1'b1;
    push(3, 32'h0000_0033);
    repeat (3) begin
      @(posedge clock);
      #1;
      checks++;
      if (bus.fifo_rd !== '0 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
          bus.out_data !== '0 || bus.out_src !== 3'd0 || dbg_state !== 2'd0) begin
        errors++;
        $display("FAIL reset_outputs: rd=%h valid=%b busy=%b data=%h src=%0d state=%0d, required all 0",
                 bus.fifo_rd, bus.out_valid, bus.busy, bus.out_data, bus.out_src, dbg_state);
      end
    end
    clear_fifos();
    reset = 1'b0;
    repeat (20) begin
      @(posedge clock);
      #1;
      checks++;
      if (bus.fifo_rd !== '0 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL idle_empty: rd=%h valid=%b busy=%b, required 0 0 0",
                 bus.fifo_rd, bus.out_valid, bus.busy);
      end
    end
  endtask

  task automatic test_single_port5();
    do_reset();
    bus.out_ready = 1'b1;
    push(5, 32'hDEAD_BEEF);
    @(posedge clock);
    #1;
    checks++;
    if (bus.fifo_rd !== 8'h20 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL p5_rd: fifo_rd=%h busy=%b, required 20 1", bus.fifo_rd, bus.busy);
    end
    @(posedge clock);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.fifo_rd !== '0) begin
      errors++;
      $display("FAIL p5_wait: valid=%b rd=%h, required 0 00", bus.out_valid, bus.fifo_rd);
    end
    @(posedge clock);
    #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hDEAD_BEEF || bus.out_src !== 3'd5) begin
      errors++;
      $display("FAIL p5_out: valid=%b data=%h src=%0d, required 1 deadbeef 5",
               bus.out_valid, bus.out_data, bus.out_src);
    end
    @(posedge clock);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL p5_done: valid=%b busy=%b, required 0 0", bus.out_valid, bus.busy);
    end
  endtask

  task automatic test_fairness();
    do_reset();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < NP; p++) push(p, 32'hA000_0000 | (32'(p) << 8) | 32'(k));
    collect(16, 120);
    checks++;
    if (got_n != 16) begin
      errors++;
      $display("FAIL fair_count: got %0d words, required 16", got_n);
    end
    for (int n = 0; n < got_n; n++) begin
      checks++;
      if (got_src[n] !== 3'(n % NP) ||
          got_data[n] !== (32'hA000_0000 | (32'(n % NP) << 8) | 32'(n / NP))) begin
        errors++;
        $display("FAIL fair_order[%0d]: src=%0d data=%h, required src=%0d", n, got_src[n], got_data[n], n % NP);
      end
      if (n > 0) begin
        checks++;
        if (got_cyc[n] - got_cyc[n-1] != 4) begin
          errors++;
          $display("FAIL fair_gap[%0d]: %0d cycles, required 4", n, got_cyc[n] - got_cyc[n-1]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    do_reset();
    push(2, 32'h1234_5678);
    wait_valid(10, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bp_valid: out_valid never rose, required 1");
    end
    for (int c = 1; c <= 8; c++) begin
      if (c == 8) bus.out_ready = 1'b1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h1234_5678 || bus.out_src !== 3'd2) begin
        errors++;
        $display("FAIL bp_hold[%0d]: valid=%b data=%h src=%0d, required 1 12345678 2",
                 c, bus.out_valid, bus.out_data, bus.out_src);
      end
      @(posedge clock);
      #1;
    end
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: valid=%b busy=%b, required 0 0", bus.out_valid, bus.busy);
    end
    push(0, 32'hB000_0000);
    push(1, 32'hB000_0001);
    push(3, 32'hB000_0003);
    collect(3, 30);
    checks++;
    if (got_n != 3 || got_src[0] !== 3'd3 || got_src[1] !== 3'd0 || got_src[2] !== 3'd1 ||
        got_data[0] !== 32'hB000_0003) begin
      errors++;
      $display("FAIL bp_next: n=%0d src=%0d,%0d,%0d, required 3 words src=3,0,1",
               got_n, got_src[0], got_src[1], got_src[2]);
    end
  endtask

  task automatic test_reset_wait();
    do_reset();
    bus.out_ready = 1'b1;
    push(6, 32'hCAFE_F00D);
    @(posedge clock);
    #1;
    checks++;
    if (bus.fifo_rd !== 8'h40) begin
      errors++;
      $display("FAIL rw_rd: fifo_rd=%h, required 40", bus.fifo_rd);
    end
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    checks++;
    if (bus.fifo_rd !== '0 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
        bus.out_data !== '0 || bus.out_src !== 3'd0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL rw_reset: rd=%h valid=%b busy=%b data=%h src=%0d state=%0d, required all 0",
               bus.fifo_rd, bus.out_valid, bus.busy, bus.out_data, bus.out_src, dbg_state);
    end
    repeat (10) begin
      @(posedge clock);
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.fifo_rd !== '0 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL rw_after: valid=%b rd=%h busy=%b, required 0 00 0",
                 bus.out_valid, bus.fifo_rd, bus.busy);
      end
    end
  endtask

  task automatic test_zero_word();
    bit ok;
    do_reset();
    bus.out_ready = 1'b1;
    push(1, 32'h0000_0000);
`ifdef ROUTER_ARB_DROP_ZERO_EN
    ok = 1'b0;
    repeat (10) begin
      @(posedge clock);
      #1;
      if (bus.out_valid === 1'b1) ok = 1'b1;
    end
    checks++;
    if (ok || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_drop: valid seen=%b busy=%b, required 0 0", ok, bus.busy);
    end
`else
    wait_valid(10, ok);
    checks++;
    if (!ok || bus.out_data !== 32'h0 || bus.out_src !== 3'd1) begin
      errors++;
      $display("FAIL zero_fwd: seen=%b data=%h src=%0d, required 1 00000000 1", ok, bus.out_data, bus.out_src);
    end
    @(posedge clock);
    #1;
`endif
    push(0, 32'hC000_0000);
    push(2, 32'hC000_0002);
    collect(2, 30);
    checks++;
    if (got_n != 2 || got_src[0] !== 3'd2 || got_src[1] !== 3'd0 || got_data[0] !== 32'hC000_0002) begin
      errors++;
      $display("FAIL zero_next: n=%0d src=%0d,%0d, required 2 words src=2,0", got_n, got_src[0], got_src[1]);
    end
  endtask

  task automatic test_random();
    int sh [NP];
    int rr, pick, remaining;
    bit prev_hold;
    logic [DW+2:0] prev_word, exp_w;
    logic [DW-1:0] d;
    do_reset();
    remaining = 0;
    for (int p = 0; p < NP; p++) begin
      int n;
      n = $urandom_range(0, 4);
      for (int k = 0; k < n; k++) begin
        d = ($urandom_range(0, 7) == 0) ? '0 : DW'($urandom);
        push(p, d);
        remaining++;
      end
      sh[p] = 0;
    end
    // Reference: plain round-robin over the queue lengths, pointer moves past each served port.
    rr = 0;
    while (remaining > 0) begin
      pick = -1;
      for (int k = 0; k < NP; k++)
        if (pick < 0 && sh[(rr + k) % NP] < tail[(rr + k) % NP]) pick = (rr + k) % NP;
      d = fmem[pick][sh[pick]];
      sh[pick]++;
      remaining--;
`ifdef ROUTER_ARB_DROP_ZERO_EN
      if (d != '0) exp_q.push_back({3'(pick), d});
`else
      exp_q.push_back({3'(pick), d});
`endif
      rr = (pick + 1) % NP;
    end
    prev_hold = 1'b0;
    prev_word = '0;
    for (int c = 0; c < 3000 && exp_q.size() > 0; c++) begin
      @(posedge clock);
      #1;
      if (prev_hold) begin
        checks++;
        if (bus.out_valid !== 1'b1 || {bus.out_src, bus.out_data} !== prev_word) begin
          errors++;
          $display("FAIL rand_stable: valid=%b word=%h, required 1 %h", bus.out_valid,
                   {bus.out_src, bus.out_data}, prev_word);
        end
      end
      bus.out_ready = ($urandom_range(0, 2) != 0);
      prev_hold = 1'b0;
      if (bus.out_valid === 1'b1) begin
        if (bus.out_ready) begin
          exp_w = exp_q.pop_front();
          checks++;
          if ({bus.out_src, bus.out_data} !== exp_w) begin
            errors++;
            $display("FAIL rand_word: src=%0d data=%h, required src=%0d data=%h",
                     bus.out_src, bus.out_data, exp_w[DW+2:DW], exp_w[DW-1:0]);
          end
        end else begin
          prev_hold = 1'b1;
          prev_word = {bus.out_src, bus.out_data};
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rand_drain: %0d words outstanding, required 0", exp_q.size());
    end
    bus.out_ready = 1'b1;
    repeat (10) begin
      @(posedge clock);
      #1;
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL rand_extra: out_valid=%b after drain, required 0", bus.out_valid);
      end
    end
  endtask

  initial begin
    bus.fifo_empty = '1;
    bus.fifo_data  = '0;
    bus.out_ready  = 1'b0;
    test_reset();
    test_single_port5();
    test_fairness();
    test_backpressure();
    test_reset_wait();
    test_zero_word();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
